// File: rtl/simmem_bank_row_tracker_pkg.sv
// Shared constants, types and delay helpers for the multi-bank row-buffer timing model.
// Bank and row fields are sliced out of the burst start address using these widths.
package simmem_bank_row_tracker_pkg;

    localparam int NumBanks       = 4;
    localparam int BankW          = $clog2(NumBanks);
    localparam int AddrW          = 19;
    localparam int RowBufLenW     = 10;
    localparam int RowIdW         = AddrW - RowBufLenW - BankW;
    localparam int RowHitCost     = 4;
    localparam int PrechargeCost  = 2;
    localparam int ActivationCost = 1;
    localparam int IidW           = 3;
    localparam int DelayW         = $clog2(RowHitCost + PrechargeCost + ActivationCost + 1);

    typedef logic [DelayW-1:0] delay_t;

    typedef enum logic [1:0] {ROW_HIT, ROW_CLOSED, ROW_CONFLICT} row_access_e;

    typedef struct packed {
        logic              open;
        logic [RowIdW-1:0] row;
    } bank_row_state_t;

    // Delay reported to the delay calculator for one access.
    function automatic delay_t get_row_delay(row_access_e access, logic closed_page);
        delay_t d;
        case (access)
            ROW_HIT:      d = delay_t'(RowHitCost);
            ROW_CONFLICT: d = delay_t'(PrechargeCost + ActivationCost + RowHitCost);
            default:      d = delay_t'(ActivationCost + RowHitCost);
        endcase
        if (closed_page) d = delay_t'(ActivationCost + RowHitCost);
        return d;
    endfunction

    // Closed-page banks also pay the auto-precharge before they can be reused.
    function automatic delay_t get_busy_cycles(row_access_e access, logic closed_page);
        return get_row_delay(access, closed_page)
             + (closed_page ? delay_t'(PrechargeCost) : delay_t'(0));
    endfunction

endpackage

// File: rtl/simmem_bank_row_tracker_if.sv
// Request/response bundle between a burst requester and the bank row tracker.
interface simmem_bank_row_tracker_if;
    import simmem_bank_row_tracker_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic [AddrW-1:0]    req_addr;
    logic [IidW-1:0]     req_iid;
    logic                flush;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IidW-1:0]     rsp_iid;
    delay_t              rsp_delay;
    logic                rsp_row_hit;
    logic [NumBanks-1:0] bank_busy;

    modport master (
        output req_valid, req_addr, req_iid, flush, rsp_ready,
        input  req_ready, rsp_valid, rsp_iid, rsp_delay, rsp_row_hit, bank_busy
    );

    modport slave (
        input  req_valid, req_addr, req_iid, flush, rsp_ready,
        output req_ready, rsp_valid, rsp_iid, rsp_delay, rsp_row_hit, bank_busy
    );

endinterface

// File: rtl/simmem_bank_row_tracker_bank_timer.sv
// One bank: open-row register plus the busy countdown started by each accepted access.
module simmem_bank_row_tracker_bank_timer
    import simmem_bank_row_tracker_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              keep_open,
    input  logic              flush,
    input  logic [RowIdW-1:0] row,
    input  delay_t            busy_cycles,
    output bank_row_state_t   state,
    output logic              busy
);

    delay_t cnt;

    // NOTE: sequential state uses non-blocking assignments so every bank samples the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= busy_cycles;
        end else if (cnt != '0) begin
            cnt <= cnt - delay_t'(1);
        end
    end

    // flush and load never coincide because flush blocks acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= '0;
        end else if (flush) begin
            state.open <= 1'b0;
        end else if (load && keep_open) begin
            state <= '{open: 1'b1, row: row};
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/simmem_bank_row_tracker.sv
// Multi-bank row-buffer timing model: classifies each accepted burst as hit/closed/conflict
// and returns its access delay, tagged with the burst internal ID.
module simmem_bank_row_tracker
    import simmem_bank_row_tracker_pkg::*;
#(
    parameter bit ClosedPage = 1'b0
) (
    input logic                     clk,
    input logic                     rst,
    simmem_bank_row_tracker_if.slave bus
);

    logic [BankW-1:0]    bank;
    logic [RowIdW-1:0]   row;
    bank_row_state_t     bank_state [NumBanks];
    bank_row_state_t     sel;
    logic [NumBanks-1:0] busy;
    row_access_e         access;
    delay_t              delay;
    delay_t              busy_cycles;
    logic                accept;

    logic                rsp_valid_q;
    logic [IidW-1:0]     rsp_iid_q;
    delay_t              rsp_delay_q;
    logic                rsp_row_hit_q;

    assign bank = bus.req_addr[RowBufLenW +: BankW];
    assign row  = bus.req_addr[AddrW-1 -: RowIdW];

    always_comb begin
        sel = bank_state[bank];
        if (ClosedPage || !sel.open) begin
            access = ROW_CLOSED;
        end else if (sel.row == row) begin
            access = ROW_HIT;
        end else begin
            access = ROW_CONFLICT;
        end
    end

    assign delay       = get_row_delay(access, ClosedPage);
    assign busy_cycles = get_busy_cycles(access, ClosedPage);

    // A stalled head request blocks everything behind it; no reordering.
    assign bus.req_ready = (!rsp_valid_q || bus.rsp_ready) && !busy[bank] && !bus.flush;
    assign accept        = bus.req_valid && bus.req_ready;

    for (genvar g = 0; g < NumBanks; g++) begin : g_bank
        simmem_bank_row_tracker_bank_timer u_timer (
            .clk         (clk),
            .rst         (rst),
            .load        (accept && (bank == BankW'(g))),
            .keep_open   (!ClosedPage),
            .flush       (bus.flush),
            .row         (row),
            .busy_cycles (busy_cycles),
            .state       (bank_state[g]),
            .busy        (busy[g])
        );
    end

    // Payload only loads on accept, which already requires the slot to be free or retiring.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q   <= 1'b0;
            rsp_iid_q     <= '0;
            rsp_delay_q   <= '0;
            rsp_row_hit_q <= 1'b0;
        end else if (accept) begin
            rsp_valid_q   <= 1'b1;
            rsp_iid_q     <= bus.req_iid;
            rsp_delay_q   <= delay;
            rsp_row_hit_q <= (access == ROW_HIT);
        end else if (bus.rsp_ready) begin
            rsp_valid_q   <= 1'b0;
        end
    end

    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_iid     = rsp_iid_q;
    assign bus.rsp_delay   = rsp_delay_q;
    assign bus.rsp_row_hit = rsp_row_hit_q;
    assign bus.bank_busy   = busy;

endmodule

// File: tb/tb_simmem_bank_row_tracker.sv
// Bench for the bank row tracker: open-page and closed-page instances share stimulus and are
// compared every cycle against a cycle-numbered reference model, plus directed vectors.
module tb_simmem_bank_row_tracker;
    import simmem_bank_row_tracker_pkg::*;

    localparam int HIT = 4, PRE = 2, ACT = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    simmem_bank_row_tracker_if bus_open ();
    simmem_bank_row_tracker_if bus_closed ();

    simmem_bank_row_tracker #(.ClosedPage(1'b0)) dut_open   (.clk(clk), .rst(rst), .bus(bus_open));
    simmem_bank_row_tracker #(.ClosedPage(1'b1)) dut_closed (.clk(clk), .rst(rst), .bus(bus_closed));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: open row per bank (-1 = none) and last busy cycle per bank, by cycle number.
    int open_row   [2][NumBanks];
    int busy_until [2][NumBanks];
    bit m_valid [2];
    int m_iid   [2];
    int m_delay [2];
    bit m_hit   [2];
    int cyc;

    bit s_v, s_flush, s_rdy;
    int s_addr, s_iid;

    function automatic int bank_of(int a);
        return (a >> RowBufLenW) % NumBanks;
    endfunction

    function automatic int row_of(int a);
        return a >> (RowBufLenW + BankW);
    endfunction

    function automatic bit m_ready(int p);
        return (!m_valid[p] || s_rdy) && (cyc > busy_until[p][bank_of(s_addr)]) && !s_flush;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            for (int b = 0; b < NumBanks; b++) begin
                open_row[p][b]   = -1;
                busy_until[p][b] = -1;
            end
            m_valid[p] = 0; m_iid[p] = 0; m_delay[p] = 0; m_hit[p] = 0;
        end
        cyc = 0;
    endtask

    task automatic drive(input bit v, input int addr, input int iid, input bit flush, input bit rdy);
        s_v = v; s_addr = addr; s_iid = iid; s_flush = flush; s_rdy = rdy;
        bus_open.req_valid   = v;   bus_closed.req_valid   = v;
        bus_open.req_addr    = AddrW'(addr); bus_closed.req_addr = AddrW'(addr);
        bus_open.req_iid     = IidW'(iid);   bus_closed.req_iid  = IidW'(iid);
        bus_open.flush       = flush; bus_closed.flush     = flush;
        bus_open.rsp_ready   = rdy;   bus_closed.rsp_ready = rdy;
    endtask

    // Compare both instances against the model in the middle of the current cycle.
    task automatic sample();
        logic g_ready, g_valid, g_hit;
        logic [IidW-1:0] g_iid;
        delay_t g_delay;
        logic [NumBanks-1:0] g_busy, e_busy;
        string tag;
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            if (p == 0) begin
                tag = "open"; g_ready = bus_open.req_ready; g_valid = bus_open.rsp_valid;
                g_iid = bus_open.rsp_iid; g_delay = bus_open.rsp_delay;
                g_hit = bus_open.rsp_row_hit; g_busy = bus_open.bank_busy;
            end else begin
                tag = "closed"; g_ready = bus_closed.req_ready; g_valid = bus_closed.rsp_valid;
                g_iid = bus_closed.rsp_iid; g_delay = bus_closed.rsp_delay;
                g_hit = bus_closed.rsp_row_hit; g_busy = bus_closed.bank_busy;
            end
            for (int b = 0; b < NumBanks; b++) e_busy[b] = (cyc <= busy_until[p][b]);
            check({tag, ".req_ready"}, g_ready, m_ready(p));
            check({tag, ".bank_busy"}, g_busy, e_busy);
            check({tag, ".rsp_valid"}, g_valid, m_valid[p]);
            if (m_valid[p]) begin
                check({tag, ".rsp_iid"},   g_iid,   m_iid[p]);
                check({tag, ".rsp_delay"}, g_delay, m_delay[p]);
                check({tag, ".rsp_hit"},   g_hit,   m_hit[p]);
            end
        end
    endtask

    // Apply this cycle's accept/handshake/flush to the model, then move to the next cycle.
    task automatic advance();
        int b, r, d, n;
        bit acc;
        for (int p = 0; p < 2; p++) begin
            acc = s_v && m_ready(p);
            if (m_valid[p] && s_rdy) m_valid[p] = 0;
            if (acc) begin
                b = bank_of(s_addr);
                r = row_of(s_addr);
                m_hit[p] = 0;
                if (p == 1) begin
                    d = ACT + HIT; n = d + PRE;
                end else begin
                    if (open_row[p][b] == r) begin
                        d = HIT; m_hit[p] = 1;
                    end else if (open_row[p][b] < 0) d = ACT + HIT;
                    else d = PRE + ACT + HIT;
                    n = d;
                    open_row[p][b] = r;
                end
                busy_until[p][b] = cyc + n;
                m_valid[p] = 1; m_iid[p] = s_iid; m_delay[p] = d;
            end
            if (s_flush) for (int k = 0; k < NumBanks; k++) open_row[p][k] = -1;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    // Asynchronous reset: asserted between edges, outputs must clear without a clock edge.
    task automatic do_reset();
        drive(0, 'h00800, 0, 0, 1);
        #2 rst = 1'b1;
        #1;
        check("rst.rsp_valid_open",   bus_open.rsp_valid,   0);
        check("rst.rsp_iid_open",     bus_open.rsp_iid,     0);
        check("rst.rsp_delay_open",   bus_open.rsp_delay,   0);
        check("rst.rsp_hit_open",     bus_open.rsp_row_hit, 0);
        check("rst.bank_busy_open",   bus_open.bank_busy,   0);
        check("rst.rsp_valid_closed", bus_closed.rsp_valid, 0);
        check("rst.bank_busy_closed", bus_closed.bank_busy, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic wait_idle();
        drive(0, 'h00800, 0, 0, 1);
        for (int k = 0; k < 20 && (bus_open.bank_busy != '0 || bus_closed.bank_busy != '0); k++) tick();
        check("idle_bound", {bus_open.bank_busy, bus_closed.bank_busy}, 0);
    endtask

    // Closed-page access to one address: delay Act+Hit, bank busy for Act+Hit+Pre cycles.
    task automatic closed_access(input int addr, input int iid);
        drive(1, addr, iid, 0, 1);
        sample();
        check("cp.req_ready", bus_closed.req_ready, 1);
        advance();
        drive(0, 'h00800, 0, 0, 1);
        for (int k = 1; k <= 8; k++) begin
            sample();
            check("cp.busy0", bus_closed.bank_busy[0], k <= 7);
            if (k == 1) begin
                check("cp.rsp_valid", bus_closed.rsp_valid, 1);
                check("cp.rsp_delay", bus_closed.rsp_delay, 5);
                check("cp.rsp_hit",   bus_closed.rsp_row_hit, 0);
            end
            advance();
        end
    endtask

    typedef struct {
        bit v; int addr; int iid; bit flush; bit rdy;
        bit e_ready; bit e_busy0; bit e_valid; int e_iid; int e_delay; bit e_hit;
    } vec_t;

    vec_t vecs [14];

    initial begin
        vecs[0]  = '{1, 'h00000, 2, 0, 1,  1, 0, 0, 0, 0, 0};
        vecs[1]  = '{1, 'h00010, 3, 0, 1,  0, 1, 1, 2, 5, 0};
        for (int i = 2; i <= 5; i++) vecs[i] = '{1, 'h00010, 3, 0, 1,  0, 1, 0, 0, 0, 0};
        vecs[6]  = '{1, 'h00010, 3, 0, 1,  1, 0, 0, 0, 0, 0};
        vecs[7]  = '{1, 'h01000, 4, 0, 1,  0, 1, 1, 3, 4, 1};
        for (int i = 8; i <= 10; i++) vecs[i] = '{1, 'h01000, 4, 0, 1,  0, 1, 0, 0, 0, 0};
        vecs[11] = '{1, 'h01000, 4, 0, 1,  1, 0, 0, 0, 0, 0};
        vecs[12] = '{1, 'h00400, 5, 0, 1,  1, 1, 1, 4, 7, 0};
        vecs[13] = '{0, 'h00800, 0, 0, 1,  1, 1, 1, 5, 5, 0};

        model_reset();
        drive(0, 'h00800, 0, 0, 1);
        @(posedge clk);
        do_reset();

        // Directed open-page vectors: closed, stalled hit, conflict, independent bank.
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].v, vecs[i].addr, vecs[i].iid, vecs[i].flush, vecs[i].rdy);
            sample();
            check($sformatf("vec%0d.req_ready", i), bus_open.req_ready, vecs[i].e_ready);
            check($sformatf("vec%0d.busy0", i), bus_open.bank_busy[0], vecs[i].e_busy0);
            check($sformatf("vec%0d.rsp_valid", i), bus_open.rsp_valid, vecs[i].e_valid);
            if (vecs[i].e_valid) begin
                check($sformatf("vec%0d.rsp_iid", i),   bus_open.rsp_iid,     vecs[i].e_iid);
                check($sformatf("vec%0d.rsp_delay", i), bus_open.rsp_delay,   vecs[i].e_delay);
                check($sformatf("vec%0d.rsp_hit", i),   bus_open.rsp_row_hit, vecs[i].e_hit);
            end
            advance();
        end

        // Response back-pressure for 4 cycles, then same-edge retire and accept.
        drive(1, 'h00800, 6, 0, 1);
        sample();
        check("bp.first_ready", bus_open.req_ready, 1);
        advance();
        drive(1, 'h00C00, 7, 0, 0);
        for (int k = 0; k < 4; k++) begin
            sample();
            check("bp.req_ready", bus_open.req_ready, 0);
            check("bp.rsp_valid", bus_open.rsp_valid, 1);
            check("bp.rsp_iid",   bus_open.rsp_iid,   6);
            check("bp.rsp_delay", bus_open.rsp_delay, 5);
            advance();
        end
        drive(1, 'h00C00, 7, 0, 1);
        sample();
        check("bp.release_ready", bus_open.req_ready, 1);
        check("bp.release_iid",   bus_open.rsp_iid,   6);
        advance();
        drive(0, 'h00800, 0, 0, 1);
        sample();
        check("bp.b2b_valid", bus_open.rsp_valid, 1);
        check("bp.b2b_iid",   bus_open.rsp_iid,   7);
        check("bp.b2b_delay", bus_open.rsp_delay, 5);
        advance();

        // Flush closes row 1 of bank 0, so row 0 comes back as closed, not conflict.
        wait_idle();
        drive(0, 'h00010, 0, 1, 1);
        sample();
        check("flush.ready_open",   bus_open.req_ready,   0);
        check("flush.ready_closed", bus_closed.req_ready, 0);
        advance();
        drive(1, 'h00010, 1, 0, 1);
        tick();
        drive(0, 'h00800, 0, 0, 1);
        sample();
        check("flush.rsp_delay", bus_open.rsp_delay,   5);
        check("flush.rsp_hit",   bus_open.rsp_row_hit, 0);
        advance();

        // Closed-page: the same address twice never hits.
        wait_idle();
        closed_access('h00000, 2);
        closed_access('h00000, 3);

        // Reset while a response is held by back-pressure.
        wait_idle();
        drive(1, 'h00800, 3, 0, 0);
        tick();
        drive(0, 'h00800, 0, 0, 0);
        sample();
        check("midrst.pending", bus_open.rsp_valid, 1);
        do_reset();
        drive(0, 'h00000, 0, 0, 1);
        tick();

        // Randomized traffic over a few rows per bank so hits, conflicts and stalls all occur.
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 9) < 7,
                  int'(($urandom_range(0, 2) << 12) | ($urandom_range(0, 3) << 10) | $urandom_range(0, 1023)),
                  int'($urandom_range(0, 7)),
                  $urandom_range(0, 29) == 0,
                  $urandom_range(0, 3) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
